// File: rtl/mexiko_boot_pkg.sv
// Shared types and constants for the boot-copy Wishbone master.
package mexiko_boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_DONE = 3'd3,
        ST_FAIL = 3'd4
    } boot_state_e;

    // Classic (non-burst) Wishbone cycle type and linear burst extension
    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;
    localparam logic [3:0] WB_SEL_ALL     = 4'hF;

    // Byte address of 32-bit word idx relative to base; wraps modulo 2^32
    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [15:0] idx);
        word_addr = base + {14'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/wb_ack_timer.sv
// Per-access response timer: counts strobe cycles that saw neither ack nor err.
// o_expired flags the TIMEOUT-th such cycle, so the master never waits longer.
module wb_ack_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

    logic [15:0] r_cnt;

    // Wait counter: cleared between accesses, advances while the strobe waits
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= 16'd0;
        end else if (i_clr) begin
            r_cnt <= 16'd0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 16'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_expired = i_en && (r_cnt >= LIMIT);

endmodule

// File: rtl/wb_bootcopy.sv
// Boot copier: reads LEN_WORDS words from the flash window at SRC_BASE and
// writes them to sysram at DST_BASE with classic Wishbone cycles, holding
// the CPU in reset until the copy is done. Bus outputs are registered; the
// strobe drops for one cycle after every completed access.
module wb_bootcopy
    import mexiko_boot_pkg::*;
#(
    parameter logic [31:0] SRC_BASE  = 32'hF100_0000,
    parameter logic [31:0] DST_BASE  = 32'h0000_0000,
    parameter int unsigned LEN_WORDS = 1024,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        start_i,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [2:0]  wb_cti_o,
    output logic [1:0]  wb_bte_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        cpu_hold_o,
    output logic        done_o,
    output logic        err_o
);

    localparam logic [16:0] LEN_W = 17'(LEN_WORDS);

    boot_state_e r_state, w_state_nxt;
    logic [15:0] r_idx, w_idx_nxt;
    logic [31:0] r_hold, w_hold_nxt;
    logic        r_bus, w_bus_nxt;
    logic        r_we, w_we_nxt;
    logic [31:0] r_adr, w_adr_nxt;
    logic [31:0] r_dat, w_dat_nxt;
    logic [3:0]  r_sel, w_sel_nxt;
    logic        r_cpu_hold, w_cpu_hold_nxt;
    logic        r_done, w_done_nxt;
    logic        r_err, w_err_nxt;

    logic        w_resp;
    logic        w_ack_ok;
    logic        w_last;
    logic        w_expired;

    // Responses only count while our strobe is out; err takes priority over ack
    assign w_resp   = r_bus & (wb_ack_i | wb_err_i);
    assign w_ack_ok = r_bus & wb_ack_i & ~wb_err_i;
    assign w_last   = ({1'b0, r_idx} + 17'd1) == LEN_W;

    wb_ack_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .i_clk     (wb_clk_i),
        .i_rst_n   (wb_rst_ni),
        .i_clr     (~r_bus | w_resp),
        .i_en      (r_bus & ~wb_ack_i & ~wb_err_i),
        .o_expired (w_expired)
    );

    // State register
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: err first, then ack, then timeout
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start_i) w_state_nxt = ST_RD;
                else         w_state_nxt = ST_IDLE;
            end
            ST_RD: begin
                if (r_bus && wb_err_i)      w_state_nxt = ST_FAIL;
                else if (r_bus && wb_ack_i) w_state_nxt = ST_WR;
                else if (w_expired)         w_state_nxt = ST_FAIL;
                else                        w_state_nxt = ST_RD;
            end
            ST_WR: begin
                if (r_bus && wb_err_i)      w_state_nxt = ST_FAIL;
                else if (r_bus && wb_ack_i) w_state_nxt = w_last ? ST_DONE : ST_RD;
                else if (w_expired)         w_state_nxt = ST_FAIL;
                else                        w_state_nxt = ST_WR;
            end
            ST_DONE: w_state_nxt = ST_DONE;
            ST_FAIL: w_state_nxt = ST_FAIL;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values of index, holding register and all registered outputs
    always_comb begin
        if (r_state == ST_IDLE && start_i) begin
            w_idx_nxt = 16'd0;
        end else if (r_state == ST_WR && w_ack_ok && !w_last) begin
            w_idx_nxt = r_idx + 16'd1;
        end else begin
            w_idx_nxt = r_idx;
        end

        if (r_state == ST_RD && w_ack_ok) w_hold_nxt = wb_dat_i;
        else                               w_hold_nxt = r_hold;

        // A completed access leaves one idle bus cycle before the next one
        w_bus_nxt = ((w_state_nxt == ST_RD) || (w_state_nxt == ST_WR)) && !w_resp;
        w_we_nxt  = w_bus_nxt && (w_state_nxt == ST_WR);

        if (!w_bus_nxt)    w_adr_nxt = 32'd0;
        else if (w_we_nxt) w_adr_nxt = word_addr(DST_BASE, w_idx_nxt);
        else               w_adr_nxt = word_addr(SRC_BASE, w_idx_nxt);

        if (w_we_nxt) w_dat_nxt = w_hold_nxt;
        else          w_dat_nxt = 32'd0;

        if (w_bus_nxt) w_sel_nxt = WB_SEL_ALL;
        else           w_sel_nxt = 4'h0;

        w_cpu_hold_nxt = (w_state_nxt != ST_DONE);
        w_done_nxt     = (w_state_nxt == ST_DONE);
        w_err_nxt      = (w_state_nxt == ST_FAIL);
    end

    // Datapath and output registers; reset abandons any access in flight
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_idx      <= 16'd0;
            r_hold     <= 32'd0;
            r_bus      <= 1'b0;
            r_we       <= 1'b0;
            r_adr      <= 32'd0;
            r_dat      <= 32'd0;
            r_sel      <= 4'h0;
            r_cpu_hold <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_idx      <= w_idx_nxt;
            r_hold     <= w_hold_nxt;
            r_bus      <= w_bus_nxt;
            r_we       <= w_we_nxt;
            r_adr      <= w_adr_nxt;
            r_dat      <= w_dat_nxt;
            r_sel      <= w_sel_nxt;
            r_cpu_hold <= w_cpu_hold_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign wb_cyc_o   = r_bus;
    assign wb_stb_o   = r_bus;
    assign wb_we_o    = r_we;
    assign wb_adr_o   = r_adr;
    assign wb_dat_o   = r_dat;
    assign wb_sel_o   = r_sel;
    assign wb_cti_o   = WB_CTI_CLASSIC;
    assign wb_bte_o   = WB_BTE_LINEAR;
    assign cpu_hold_o = r_cpu_hold;
    assign done_o     = r_done;
    assign err_o      = r_err;

endmodule
